// File: rtl/cmd_pkg.sv
// Shared definitions for the command parser: default widths, well-known
// command ids, parser state and decode error codes, and the VLQ step function.
package cmd_pkg;

    localparam int unsigned CMD_BITS_DFLT = 8;
    localparam int unsigned VLQ_MAX_BYTES = 5;

    localparam logic [7:0] CMD_NOP   = 8'd0;
    localparam logic [7:0] CMD_PWM   = 8'd1;
    localparam logic [7:0] CMD_STEP  = 8'd2;
    localparam logic [7:0] CMD_CFG   = 8'd3;

    typedef enum logic [1:0] {
        S_ID,
        S_ARGS,
        S_PRESENT,
        S_DISCARD
    } state_e;

    typedef enum logic [1:0] {
        E_NONE,
        E_LONG,
        E_UNK,
        E_TRUNC
    } err_e;

    // One VLQ byte folded into the accumulator. The first byte of a value
    // sign-extends from bit 5 when bits 6:5 are both set; continuation bytes
    // shift left by 7 and bits shifted past bit 31 are lost.
    function automatic logic [31:0] vlq_step(input logic [31:0] acc,
                                             input logic        first,
                                             input logic [7:0]  c);
        logic [31:0] v;
        if (first) begin
            v = {25'd0, c[6:0]};
            if (c[6:5] == 2'b11) begin
                v = v | ~32'h0000_001F;
            end
        end else begin
            v = (acc << 7) | {25'd0, c[6:0]};
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/clear. Clear wins over push and pop in the
// same cycle. Read data is forced to zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Pointer next-state: clear rewinds both pointers to the same slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cmd_vlq_parser.sv
// Host message parser: decodes a VLQ byte stream into a command id plus args,
// buffers args in a FIFO and presents one command at a time to the consumers.
module cmd_vlq_parser
    import cmd_pkg::*;
#(
    parameter int unsigned        CMD_BITS    = CMD_BITS_DFLT,
    parameter int unsigned        NCMDS       = 16,
    parameter logic [NCMDS*4-1:0] NARGS_TABLE = '0,
    parameter int unsigned        ARG_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [CMD_BITS-1:0] cmd,
    output logic                cmd_ready,
    output logic [31:0]         arg_data,
    input  logic                arg_advance,
    input  logic                cmd_done,
    output logic                parse_error
);

    localparam int unsigned IDX_W = (NCMDS > 1) ? $clog2(NCMDS) : 1;

    state_e              state_q, state_d;
    logic [31:0]         acc_q, acc_d;
    logic [2:0]          bcnt_q, bcnt_d;
    logic [3:0]          argcnt_q, argcnt_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic                perr_q, perr_d;
    err_e                err;

    logic                accept, val_done, too_long;
    logic [31:0]         vnext;
    logic [NCMDS*4-1:0]  tbl_sh;
    logic [3:0]          nargs;
    logic                fifo_push, fifo_pop, fifo_clear, fifo_empty, fifo_full;

    assign in_ready    = rst_n && (state_q != S_PRESENT);
    assign cmd_ready   = (state_q == S_PRESENT);
    assign cmd         = cmd_q;
    assign parse_error = perr_q;
    assign fifo_pop    = arg_advance && cmd_ready && !fifo_empty;

    // Per-byte VLQ datapath and arg-count lookup for the value just completed.
    always_comb begin
        accept   = in_valid && in_ready;
        val_done = !in_data[7];
        too_long = (bcnt_q == 3'(VLQ_MAX_BYTES));
        vnext    = vlq_step(acc_q, (bcnt_q == '0), in_data);
        tbl_sh   = NARGS_TABLE >> {vnext[IDX_W-1:0], 2'b00};
        nargs    = tbl_sh[3:0];
    end

    // Parser FSM next-state, FIFO control and error classification.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bcnt_d     = bcnt_q;
        argcnt_d   = argcnt_q;
        cmd_d      = cmd_q;
        err        = E_NONE;
        fifo_push  = 1'b0;
        fifo_clear = 1'b0;

        unique case (state_q)
            S_ID, S_ARGS: begin
                if (accept) begin
                    // Every accepted byte either extends or closes a value,
                    // so the accumulator restarts on any outcome except extend.
                    acc_d  = '0;
                    bcnt_d = '0;
                    if (too_long) begin
                        err        = E_LONG;
                        fifo_clear = 1'b1;
                        state_d    = in_last ? S_ID : S_DISCARD;
                    end else if (!val_done) begin
                        if (in_last) begin
                            err        = E_TRUNC;
                            fifo_clear = 1'b1;
                            state_d    = S_ID;
                        end else begin
                            acc_d  = vnext;
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else if (state_q == S_ID) begin
                        if (vnext >= NCMDS) begin
                            err        = E_UNK;
                            fifo_clear = 1'b1;
                            state_d    = in_last ? S_ID : S_DISCARD;
                        end else begin
                            cmd_d = vnext[CMD_BITS-1:0];
                            if (nargs == '0) begin
                                state_d = S_PRESENT;
                            end else if (in_last) begin
                                // Message ended before any of the args arrived.
                                err        = E_TRUNC;
                                fifo_clear = 1'b1;
                                state_d    = S_ID;
                            end else begin
                                argcnt_d = nargs;
                                state_d  = S_ARGS;
                            end
                        end
                    end else begin
                        argcnt_d = argcnt_q - 4'd1;
                        if (argcnt_q == 4'd1) begin
                            fifo_push = !fifo_full;
                            state_d   = S_PRESENT;
                        end else if (in_last) begin
                            err        = E_TRUNC;
                            fifo_clear = 1'b1;
                            state_d    = S_ID;
                        end else begin
                            fifo_push = !fifo_full;
                        end
                    end
                end
            end
            S_PRESENT: begin
                if (cmd_done) begin
                    fifo_clear = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_DISCARD: begin
                if (accept && in_last) begin
                    state_d = S_ID;
                end
            end
            default: state_d = S_ID;
        endcase

        perr_d = (err != E_NONE);
    end

    // Parser state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ID;
            acc_q    <= '0;
            bcnt_q   <= '0;
            argcnt_q <= '0;
            cmd_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bcnt_q   <= bcnt_d;
            argcnt_q <= argcnt_d;
            cmd_q    <= cmd_d;
            perr_q   <= perr_d;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (ARG_DEPTH)
    ) u_arg_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (fifo_clear),
        .wr_data (vnext),
        .rd_data (arg_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_cmd_vlq_parser.sv
// Scoreboard bench for cmd_vlq_parser: directed byte messages, expected
// commands/errors queued at issue time, consumer-side monitor pops and checks.
module tb_cmd_vlq_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic [31:0] arg_data;
    logic        arg_advance;
    logic        cmd_done;
    logic        parse_error;

    // Command k has nibble k args: cmd0=0, cmd1=2, cmd2=4, cmd3=1.
    cmd_vlq_parser #(
        .CMD_BITS    (8),
        .NCMDS       (16),
        .NARGS_TABLE (64'h0000_0000_0000_1420),
        .ARG_DEPTH   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .arg_data    (arg_data),
        .arg_advance (arg_advance),
        .cmd_done    (cmd_done),
        .parse_error (parse_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               is_err;
        logic [7:0]       cmd;
        int unsigned      nargs;
        int unsigned      npop;
        logic [3:0][31:0] args;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        ev;
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cstate;
    int unsigned k;
    bit          hold_adv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1;
        e.cmd    = '0;
        e.nargs  = 0;
        e.npop   = 0;
        e.args   = '0;
        q.push_back(e);
    endtask

    task automatic exp_cmd(input logic [7:0] c, input int unsigned n, input int unsigned np,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        exp_t e;
        e.is_err  = 1'b0;
        e.cmd     = c;
        e.nargs   = n;
        e.npop    = np;
        e.args[0] = a0;
        e.args[1] = a1;
        e.args[2] = a2;
        e.args[3] = a3;
        q.push_back(e);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int unsigned n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q.size() != 0 || cstate != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    // Monitor / consumer: pops the scoreboard on every parse_error pulse and on
    // every new cmd_ready, reads args in order, then pulses cmd_done.
    initial begin
        arg_advance = 1'b0;
        cmd_done    = 1'b0;
        cstate      = 0;
        k           = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cstate      = 0;
                arg_advance = 1'b0;
                cmd_done    = 1'b0;
            end else begin
                if (parse_error) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL err_unexpected: got parse_error expected no event");
                    end else begin
                        ev = q.pop_front();
                        chk("err_kind", {31'd0, ev.is_err}, 32'd1);
                    end
                end
                if (cstate == 2) begin
                    cmd_done    = 1'b0;
                    arg_advance = hold_adv;
                    chk("cmd_ready_clr", {31'd0, cmd_ready}, 32'd0);
                    chk("in_ready_after_done", {31'd0, in_ready}, 32'd1);
                    chk("fifo_flushed", arg_data, 32'd0);
                    cstate = 0;
                end else begin
                    if (cstate == 0) begin
                        cmd_done    = 1'b0;
                        arg_advance = hold_adv;
                        if (cmd_ready) begin
                            if (q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL cmd_unexpected: got cmd %h expected no event", cmd);
                            end else begin
                                cur = q.pop_front();
                                chk("cmd_kind", {31'd0, cur.is_err}, 32'd0);
                                chk("cmd_id", {24'd0, cmd}, {24'd0, cur.cmd});
                                k      = 0;
                                cstate = 1;
                            end
                        end
                    end
                    if (cstate == 1) begin
                        chk("cmd_ready_held", {31'd0, cmd_ready}, 32'd1);
                        chk("cmd_stable", {24'd0, cmd}, {24'd0, cur.cmd});
                        if (k < cur.npop) begin
                            chk($sformatf("arg%0d", k), arg_data, cur.args[k]);
                            arg_advance = 1'b1;
                            k++;
                        end else begin
                            chk("arg_tail", arg_data,
                                (cur.npop < cur.nargs) ? cur.args[cur.npop] : 32'd0);
                            arg_advance = hold_adv;
                            cmd_done    = 1'b1;
                            cstate      = 2;
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_vec    = 0;
        n_err    = 0;
        hold_adv = 1'b0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_cmd", {24'd0, cmd}, 32'd0);
        chk("rst_arg_data", arg_data, 32'd0);
        chk("rst_parse_error", {31'd0, parse_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Four args including a two-byte value and a zero.
        exp_cmd(8'd2, 4, 4, 32'd5, 32'd64, 32'd1, 32'd0);
        send_byte(8'h02, 0); send_byte(8'h05, 0); send_byte(8'h80, 0);
        send_byte(8'h40, 0); send_byte(8'h01, 0); send_byte(8'h00, 1);
        drain();

        // Sign extension and continuation.
        exp_cmd(8'd3, 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
        send_byte(8'h03, 0); send_byte(8'h7F, 1);
        exp_cmd(8'd3, 1, 1, 32'hFFFF_FFE0, 0, 0, 0);
        send_byte(8'h03, 0); send_byte(8'h60, 1);
        exp_cmd(8'd3, 1, 1, 32'd128, 0, 0, 0);
        send_byte(8'h03, 0); send_byte(8'h81, 0); send_byte(8'h00, 1);
        drain();

        // Unknown id: rest discarded, next message (zero-arg cmd 0) decodes.
        exp_err();
        send_byte(8'h20, 0); send_byte(8'hAA, 0); send_byte(8'h3B, 0); send_byte(8'h0C, 1);
        exp_cmd(8'd0, 0, 0, 0, 0, 0, 0);
        send_byte(8'h00, 1);
        drain();

        // Unknown (negative) id on a last byte: back to S_ID without discard.
        exp_err();
        send_byte(8'h7F, 1);
        exp_cmd(8'd0, 0, 0, 0, 0, 0, 0);
        send_byte(8'h00, 1);
        drain();

        // Truncated message: FIFO cleared, following message clean.
        exp_err();
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 1);
        exp_cmd(8'd1, 2, 2, 32'd3, 32'd4, 0, 0);
        send_byte(8'h01, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
        drain();

        // Six-byte value: E_LONG, trailing bytes discarded.
        exp_err();
        send_byte(8'h03, 0);
        for (int i = 0; i < 5; i++) send_byte(8'h81, 0);
        send_byte(8'h01, 0); send_byte(8'h55, 0); send_byte(8'h66, 1);
        exp_cmd(8'd3, 1, 1, 32'd5, 0, 0, 0);
        send_byte(8'h03, 0); send_byte(8'h05, 1);
        drain();

        // Consumer holds arg_advance high, takes two args then finishes.
        hold_adv = 1'b1;
        exp_cmd(8'd2, 4, 2, 32'd9, 32'd8, 32'd7, 32'd6);
        send_byte(8'h02, 0); send_byte(8'h09, 0); send_byte(8'h08, 0);
        send_byte(8'h07, 0); send_byte(8'h06, 1);
        drain();
        hold_adv = 1'b0;
        @(negedge clk);

        // Reset in the middle of the args.
        send_byte(8'h02, 0); send_byte(8'h05, 0); send_byte(8'h80, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_arg_data", arg_data, 32'd0);
        chk("midrst_cmd", {24'd0, cmd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_cmd(8'd1, 2, 2, 32'd3, 32'd4, 0, 0);
        send_byte(8'h01, 0); send_byte(8'h03, 0); send_byte(8'h04, 1);
        drain();

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
